fetch_step_ctrl: RTL and testbench

// - Sequences the instruction fetch unit from board buttons: single-step, free-run and PC clear.
// - Inputs are already-debounced button levels; the block edge-detects them and issues fetch

---
 rtl/fetch_step_ctrl_pkg.sv | 16 +
 rtl/fetch_step_ctrl_if.sv | 11 +
 rtl/fetch_step_ctrl_edge_detect.sv | 21 ++
 rtl/fetch_step_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_step_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_step_ctrl_pkg.sv
// Shared types for the fetch step controller.
//   ctrl_state_t : sequencer state encoding
//   STEP_CNT_W   : width of the completed-handshake counter
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STEP_REQ  = 3'd1,
    HOLD_WAIT = 3'd2,
    REPEAT    = 3'd3,
    RUN       = 3'd4
  } ctrl_state_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/fetch_step_ctrl_if.sv
// Fetch request handshake between the step controller and the fetch datapath.
//   fetch_req   : controller asks for one PC advance / instruction fetch
//   fetch_ready : fetch unit accepts the advance this cycle
// A transfer happens on any cycle where both are high.
interface fetch_step_ctrl_if;
  logic fetch_req;
  logic fetch_ready;

  modport master (output fetch_req, input fetch_ready);
  modport slave  (input fetch_req, output fetch_ready);
endinterface

// File: rtl/fetch_step_ctrl_edge_detect.sv
// Rising-edge detector for an already-debounced button level.
//   clk, rst_n : clock, async active-low reset
//   din        : button level
//   rise       : high for the cycle where din is high and was low last cycle
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/fetch_step_ctrl.sv
// Board-button sequencer for the instruction fetch unit: single step, step
// auto-repeat while held, free-run, and PC clear.
//   clk, rst_n    : clock, async active-low reset
//   btn_step      : debounced step button level
//   btn_run       : debounced run/stop toggle level
//   btn_clr       : debounced PC-clear level
//   fetch_bus     : req/ready handshake to the fetch datapath (master side)
//   pc_clear      : one-cycle pulse telling the fetch unit to zero its PC
//   run_active    : high in RUN mode (LED)
//   step_count    : completed handshakes since reset/clear, wraps
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a step or run button edge
// STEP_REQ  | single-step request outstanding
// HOLD_WAIT | step button still held, timing the auto-repeat hold-off
// REPEAT    | auto-repeat: one request every REPEAT_DIV cycles
// RUN       | free-run: one request every RUN_DIV cycles
module fetch_step_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV     = 50_000_000,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned REPEAT_DIV  = 10_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_step,
  input  logic                   btn_run,
  input  logic                   btn_clr,
  fetch_step_ctrl_if.master      fetch_bus,
  output logic                   pc_clear,
  output logic                   run_active,
  output logic [STEP_CNT_W-1:0]  step_count
);

  // Periodic requests are raised at DIV-2 so that, with ready high, the
  // wait cycles plus the request cycle add up to exactly DIV cycles.
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_DIV - 2);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_DIV - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);

  logic step_rise, run_rise, clr_rise;
  logic xfer;

  ctrl_state_t           state_q;
  logic [CNT_W-1:0]      timer_q;
  logic                  fetch_req_q;
  logic                  pc_clear_q;
  logic                  run_active_q;
  logic                  stop_pend_q;
  logic [STEP_CNT_W-1:0] step_count_q;

  edge_detect u_ed_step (.clk(clk), .rst_n(rst_n), .din(btn_step), .rise(step_rise));
  edge_detect u_ed_run  (.clk(clk), .rst_n(rst_n), .din(btn_run),  .rise(run_rise));
  edge_detect u_ed_clr  (.clk(clk), .rst_n(rst_n), .din(btn_clr),  .rise(clr_rise));

  assign xfer = fetch_req_q & fetch_bus.fetch_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      fetch_req_q  <= 1'b0;
      pc_clear_q   <= 1'b0;
      run_active_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      pc_clear_q <= 1'b0;
      if (clr_rise) begin
        // Clear wins over everything; an outstanding request is dropped uncounted.
        state_q      <= IDLE;
        timer_q      <= '0;
        fetch_req_q  <= 1'b0;
        pc_clear_q   <= 1'b1;
        run_active_q <= 1'b0;
        stop_pend_q  <= 1'b0;
        step_count_q <= '0;
      end else begin
        if (xfer) begin
          fetch_req_q  <= 1'b0;
          timer_q      <= '0;
          step_count_q <= step_count_q + 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (run_rise) begin
              state_q      <= RUN;
              run_active_q <= 1'b1;
              timer_q      <= '0;
            end else if (step_rise) begin
              state_q     <= STEP_REQ;
              fetch_req_q <= 1'b1;
              timer_q     <= '0;
            end
          end
          STEP_REQ: begin
            if (xfer) state_q <= btn_step ? HOLD_WAIT : IDLE;
          end
          HOLD_WAIT: begin
            if (!btn_step) begin
              state_q <= IDLE;
            end else if (timer_q == HOLD_LAST) begin
              state_q <= REPEAT;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TMR_ONE;
            end
          end
          REPEAT: begin
            if (fetch_req_q) begin
              // Release is only honoured once the outstanding request completes.
              if (xfer && !btn_step) state_q <= IDLE;
            end else if (!btn_step) begin
              state_q <= IDLE;
            end else if (timer_q == REP_LAST) begin
              fetch_req_q <= 1'b1;
              timer_q     <= '0;
            end else begin
              timer_q <= timer_q + TMR_ONE;
            end
          end
          RUN: begin
            if (fetch_req_q) begin
              // A stop edge seen while a request is outstanding is remembered
              // and takes effect on the transfer.
              if (xfer && (run_rise || stop_pend_q)) begin
                state_q      <= IDLE;
                run_active_q <= 1'b0;
                stop_pend_q  <= 1'b0;
              end else if (run_rise) begin
                stop_pend_q <= 1'b1;
              end
            end else if (run_rise) begin
              state_q      <= IDLE;
              run_active_q <= 1'b0;
            end else if (timer_q == RUN_LAST) begin
              fetch_req_q <= 1'b1;
              timer_q     <= '0;
            end else begin
              timer_q <= timer_q + TMR_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fetch_bus.fetch_req = fetch_req_q;
  assign pc_clear            = pc_clear_q;
  assign run_active          = run_active_q;
  assign step_count          = step_count_q;

endmodule

// File: tb/tb_fetch_step_ctrl.sv
// Directed bench for fetch_step_ctrl with short timer parameters.
module tb_fetch_step_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_step = 1'b0;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;
  logic pc_clear;
  logic run_active;
  logic [STEP_CNT_W-1:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;
  int req_hi = 0;
  int xfer_cnt = 0;

  fetch_step_ctrl_if bus ();

  fetch_step_ctrl #(
    .RUN_DIV(8), .HOLD_CYCLES(20), .REPEAT_DIV(4), .CNT_W(27)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_step(btn_step), .btn_run(btn_run), .btn_clr(btn_clr),
    .fetch_bus(bus),
    .pc_clear(pc_clear), .run_active(run_active), .step_count(step_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fetch_req) req_hi++;
    if (bus.fetch_req && bus.fetch_ready) xfer_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_ready = 1'b1;
    #12;
    check("rst_req", bus.fetch_req, 0);
    check("rst_clr", pc_clear, 0);
    check("rst_run", run_active, 0);
    check("rst_cnt", step_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Short step press: one request, one count
    req_hi = 0;
    btn_step = 1'b1;
    cyc(1);
    check("s1_req_up", bus.fetch_req, 1);
    cyc(1);
    check("s1_req_dn", bus.fetch_req, 0);
    check("s1_cnt", step_count, 1);
    cyc(1);
    btn_step = 1'b0;
    cyc(3);
    check("s1_cnt_end", step_count, 1);
    check("s1_req_cycles", req_hi, 1);

    // Held step: initial request, 20-cycle hold, repeats every 4 cycles
    req_hi = 0;
    btn_step = 1'b1;
    cyc(24);
    check("s2_hold_cnt", step_count, 2);
    check("s2_hold_noreq", bus.fetch_req, 0);
    cyc(1);
    check("s2_first_rep", bus.fetch_req, 1);
    cyc(15);
    btn_step = 1'b0;
    cyc(3);
    check("s2_cnt", step_count, 6);
    check("s2_req_cycles", req_hi, 5);
    check("s2_idle_req", bus.fetch_req, 0);

    // Run mode: one transfer every 8 cycles, stop on second edge
    xfer_cnt = 0;
    btn_run = 1'b1;
    cyc(1);
    check("r_active_on", run_active, 1);
    cyc(1);
    btn_run = 1'b0;
    cyc(48);
    check("r_active_mid", run_active, 1);
    check("r_cnt_mid", step_count, 12);
    btn_run = 1'b1;
    cyc(1);
    check("r_active_off", run_active, 0);
    btn_run = 1'b0;
    cyc(10);
    check("r_cnt", step_count, 12);
    check("r_xfers", xfer_cnt, 6);
    check("r_req_idle", bus.fetch_req, 0);

    // Ready held low: request holds, single transfer
    req_hi = 0;
    bus.fetch_ready = 1'b0;
    btn_step = 1'b1;
    cyc(1);
    check("w_req_up", bus.fetch_req, 1);
    cyc(10);
    check("w_req_held", bus.fetch_req, 1);
    check("w_cnt_frozen", step_count, 12);
    btn_step = 1'b0;
    bus.fetch_ready = 1'b1;
    cyc(1);
    check("w_cnt", step_count, 13);
    check("w_req_dn", bus.fetch_req, 0);
    cyc(3);
    check("w_cnt_end", step_count, 13);
    check("w_req_cycles", req_hi, 11);

    // Stop edge while a run request is outstanding
    bus.fetch_ready = 1'b0;
    btn_run = 1'b1;
    cyc(1);
    btn_run = 1'b0;
    cyc(8);
    check("p_req_pend", bus.fetch_req, 1);
    btn_run = 1'b1;
    cyc(1);
    btn_run = 1'b0;
    check("p_still_run", run_active, 1);
    cyc(2);
    check("p_still_run2", run_active, 1);
    check("p_req_held", bus.fetch_req, 1);
    bus.fetch_ready = 1'b1;
    cyc(1);
    check("p_stopped", run_active, 0);
    check("p_cnt", step_count, 14);
    cyc(10);
    check("p_cnt_end", step_count, 14);
    check("p_req_idle", bus.fetch_req, 0);

    // Asynchronous reset during an outstanding request
    bus.fetch_ready = 1'b0;
    btn_step = 1'b1;
    cyc(1);
    check("a_req_up", bus.fetch_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_req_rst", bus.fetch_req, 0);
    check("a_cnt_rst", step_count, 0);
    btn_step = 1'b0;
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Clear + run + step edges together while running
    btn_run = 1'b1;
    cyc(1);
    btn_run = 1'b0;
    cyc(9);
    check("c_cnt_pre", step_count, 1);
    btn_clr = 1'b1;
    btn_run = 1'b1;
    btn_step = 1'b1;
    cyc(1);
    check("c_pulse", pc_clear, 1);
    check("c_cnt", step_count, 0);
    check("c_run_off", run_active, 0);
    check("c_req", bus.fetch_req, 0);
    cyc(1);
    check("c_pulse_end", pc_clear, 0);
    btn_clr = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    req_hi = 0;
    cyc(12);
    check("c_idle_cnt", step_count, 0);
    check("c_idle_run", run_active, 0);
    check("c_idle_reqs", req_hi, 0);

    // Counter wrap 0xFFFF -> 0
    force dut.step_count_q = 16'hFFFF;
    cyc(1);
    release dut.step_count_q;
    cyc(1);
    check("wrap_pre", step_count, 32'hFFFF);
    btn_step = 1'b1;
    cyc(1);
    btn_step = 1'b0;
    cyc(2);
    check("wrap_post", step_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
